// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM encoding and width limits for serial_subtractor
package serial_sub_pkg;

  // Controller states: waiting for a request, or stepping through operand bits
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sub_state_e;

  // Legal operand widths for the serial datapath
  localparam int SUB_WIDTH_MIN = 2;
  localparam int SUB_WIDTH_MAX = 32;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor cell (a - b - bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of a single bit position
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B, LSB first; signed overflow output with SERIAL_SUB_OVERFLOW_EN
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < SUB_WIDTH_MIN || WIDTH > SUB_WIDTH_MAX) begin : g_bad_width
    $error("serial_subtractor: WIDTH out of range");
  end

  sub_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             fs_d, fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // The single arithmetic cell always looks at bit 0 of the operand shifters
  full_subtractor u_full_subtractor (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state: accept a request in IDLE, process one bit per cycle in SHIFT
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_sr_d  = A;
          b_sr_d  = B;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
`endif
        end
      end
      ST_SHIFT: begin
        // Result fills from the MSB side so after WIDTH steps bit 0 lands at index 0
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        res_d  = {fs_d, res_q[WIDTH-1:1]};
        bin_d  = fs_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the full result at once, never a partial one
          state_d  = ST_IDLE;
          diff_d   = {fs_d, res_q[WIDTH-1:1]};
          borrow_d = fs_bout;
          done_d   = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // fs_d is the difference MSB at this step
          ovf_d    = (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = done_q;
  assign Diff   = diff_q;
  assign Borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign Overflow = ovf_q;
`endif

endmodule : serial_subtractor
